// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: pairs an issued branch/jump with next-cycle
// comparator verdict, offers a held redirect to fetch, or raises a misaligned trap.
module branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic [2:0]      function_select,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    input  logic            cmp_result,
    output logic            stall_out,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] taken_count,
    output logic [1:0]      state_dbg
);

    // Redirect handshake: redirect_valid is held with redirect_pc stable until a
    // cycle where redirect_valid & redirect_ready; redirect_ready alone does nothing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] e1_pc;
    logic [XLEN-1:0] e1_target;
    logic            e1_jump;
    logic            e1_branch;
    logic            taken;
    logic            aligned;
    logic            capture;

    // funct3 is routed straight to the comparator; nothing here decodes it.
    logic unused_function_select;
    assign unused_function_select = ^function_select;

    assign stall_out      = (state == PENDING);
    assign redirect_valid = (state == PENDING);
    assign state_dbg      = state;

    always_comb begin
        taken     = (state == RESOLVE) && (e1_jump || (e1_branch && cmp_result));
        aligned   = (e1_target[1:0] == 2'b00);
        // A taken resolution kills whatever is presented in the same cycle.
        capture   = valid_in && (is_branch || is_jump) && !stall_out && !taken;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                if (taken)        state_nxt = aligned ? PENDING : IDLE;
                else if (capture) state_nxt = RESOLVE;
                else              state_nxt = IDLE;
            end
            PENDING: begin
                if (redirect_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            e1_pc        <= '0;
            e1_target    <= '0;
            e1_jump      <= 1'b0;
            e1_branch    <= 1'b0;
            redirect_pc  <= '0;
            flush        <= 1'b0;
            trap_valid   <= 1'b0;
            trap_pc      <= '0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            state      <= state_nxt;
            flush      <= taken && aligned;
            trap_valid <= taken && !aligned;
            if (capture) begin
                e1_pc     <= pc;
                e1_target <= target;
                e1_jump   <= is_jump;
                e1_branch <= is_branch;
            end
            if (taken && aligned)  redirect_pc <= e1_target;
            if (taken && !aligned) trap_pc     <= e1_pc;
            if ((state == RESOLVE) && e1_branch) begin
                branch_count <= branch_count + XLEN'(1);
                if (taken) taken_count <= taken_count + XLEN'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the pipelined RV32I core. It pairs a branch or jump issued in cycle N with the registered comparator verdict that arrives in cycle N+1, and decides taken or not-taken under static not-taken prediction. Taken, aligned branches produce a held redirect to fetch over a valid/ready handshake, plus a flush pulse. Misaligned targets raise a one-cycle trap instead.

## Interface
- `XLEN`, 32, width of PC, target and counters
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `valid_in` in 1: the instruction on the issue inputs is valid this cycle
- `is_branch` in 1: conditional branch (BEQ..BGEU)
- `is_jump` in 1: unconditional jump (JAL/JALR); the comparator verdict is ignored
- `function_select` in 3: branch funct3, forwarded unchanged to the comparator; this block does not interpret it
- `pc` in XLEN: PC of the issued instruction
- `target` in XLEN: computed branch/jump target
- `cmp_result` in 1: comparator verdict for the instruction issued the previous cycle
- `stall_out` out 1: upstream must hold its issue inputs
- `redirect_valid` out 1: a redirect is offered to fetch
- `redirect_ready` in 1: fetch accepts the redirect
- `redirect_pc` out XLEN: new fetch address
- `flush` out 1: one-cycle pulse that kills younger instructions in IF/ID
- `trap_valid` out 1: one-cycle misaligned-target trap
- `trap_pc` out XLEN: PC of the faulting instruction
- `branch_count` out XLEN: number of conditional branches resolved (wraps)
- `taken_count` out XLEN: number of conditional branches resolved taken (wraps)

## Operation
- States: IDLE, RESOLVE, PENDING.
- **Capture.** An instruction is captured into the E1 register (pc, target, is_jump, is_branch) when all of these hold: `valid_in`, `is_branch|is_jump`, `!stall_out`, and no kill (below). The state then goes to RESOLVE. Valid non-control instructions pass through without changing state.
- **RESOLVE.** Compute `taken = is_jump | (is_branch & cmp_result)`.
  - Not taken: return to IDLE, or stay in RESOLVE if a new capture occurs this cycle.
  - Taken with `target[1:0]==0`: latch `redirect_pc=target` and go to PENDING.
  - Taken with `target[1:0]!=0`: register `trap_valid=1` and `trap_pc=E1.pc` for the next cycle, with no redirect and no flush, then go to IDLE.
- **Kill.** A taken result in RESOLVE (aligned or not) kills the instruction presented at `valid_in` in the same cycle. It is not captured and no counter changes for it.
- **PENDING.**
  - `redirect_valid=1`; `redirect_pc` is stable until accepted.
  - `flush=1` only in the first PENDING cycle.
  - `stall_out=1` throughout.
  - Leave on `redirect_valid & redirect_ready` and go to IDLE. `stall_out` drops the following cycle.
- **Counters.**
  - `branch_count` increments by 1 on each RESOLVE cycle with `is_branch`.
  - `taken_count` also increments when that branch is taken, including misaligned-trap cases.
  - Jumps are not counted. Both counters wrap modulo 2^XLEN.
- **Reset.** Asserting `reset_n` low at any time, including in PENDING, clears the following:
  - state goes to IDLE;
  - `redirect_valid`, `flush`, `trap_valid`, `stall_out` go to 0;
  - `redirect_pc`, `trap_pc`, both counters and the E1 register go to 0.

  An outstanding redirect is dropped.

## Timing
- Issue in cycle N; `cmp_result` is sampled in cycle N+1.
- Taken aligned branch: `redirect_valid` and `flush` rise in N+2. The earliest acceptance is N+2, and the next capture is possible in N+3.
- Not-taken branch: no outputs change. A new branch may be captured every cycle, back to back.
- Misaligned taken: `trap_valid` is high for exactly cycle N+2.
- `stall_out` is combinational from state (`state==PENDING`). It never depends on `valid_in`.
- `redirect_ready` held low: `redirect_valid` and `redirect_pc` are held indefinitely, and `flush` does not repeat.
- `redirect_ready` high while not in PENDING is ignored.

## Test plan
- **Not taken.** BEQ, pc=0x100, target=0x200, cmp_result=0 in N+1 -> no redirect, no flush; branch_count=1, taken_count=0.
- **Taken, ready high.** BNE, pc=0x100, target=0x40, cmp_result=1 -> redirect_valid and flush in N+2, redirect_pc=0x40, accepted in N+2. The instruction issued in N+1 is killed, and its pc never appears on redirect or trap.
- **Backpressure.** JAL, target=0x1000, redirect_ready low for 5 cycles -> redirect_valid held 6 cycles, flush for 1 cycle, stall_out high until the cycle after acceptance; counters unchanged.
- **Misaligned.** BLT taken, pc=0x80, target=0x202 -> trap_valid=1 only in N+2 with trap_pc=0x80, no redirect; taken_count=1.
- **Reset in PENDING.** Drop reset_n mid-PENDING -> all outputs 0 immediately. After release, a fresh not-taken branch increments branch_count to 1.
- **Wrap.** Preload via 2^XLEN-1 taken branches, or force the counter -> the next taken branch wraps taken_count to 0.
